// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with a Mealy match pulse and KMP-style fallback on mismatch.
// Define SEQ_DETECTOR_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt/cnt_sat read 0.
module seq_detector_param #(
    parameter int unsigned      LEN     = 4,
    parameter logic [LEN-1:0]   PATTERN = 4'b1001,
    parameter bit               OVERLAP = 1'b0,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int unsigned KW = (LEN > 1) ? $clog2(LEN) : 1;

    typedef logic [KW-1:0]       k_t;
    typedef k_t   [LEN-1:0]      tbl_t;

    // Entry k: longest proper prefix of PATTERN that ends the string (first k pattern bits, then b).
    // Covers the advance (k+1), the mismatch fallback and, at k=LEN-1, the overlap restart F(LEN).
    function automatic tbl_t build_tbl(input logic b);
        tbl_t        t;
        int unsigned best;
        int unsigned j;
        logic        sbit;
        logic        ok;
        t = '0;
        for (int unsigned k = 0; k < LEN; k++) begin
            best = 0;
            for (int unsigned l = 1; (l <= k + 1) && (l < LEN); l++) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < l; i++) begin
                    j    = k + 1 - l + i;
                    sbit = (j == k) ? b : PATTERN[LEN-1-j];
                    if (sbit != PATTERN[LEN-1-i]) ok = 1'b0;
                end
                if (ok) best = l;
            end
            t[k] = k_t'(best);
        end
        return t;
    endfunction

    localparam tbl_t NXT0 = build_tbl(1'b0);
    localparam tbl_t NXT1 = build_tbl(1'b1);

    k_t   k;
    logic e;
    logic hit;

    assign e   = PATTERN[k_t'(LEN - 1) - k];
    assign hit = in_valid && (in == e) && (k == k_t'(LEN - 1));
    assign out = !rst && hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            k <= '0;
        end else if (in_valid) begin
            if (hit && !OVERLAP) begin
                k <= '0;
            end else begin
                k <= in ? NXT1[k] : NXT0[k];
            end
        end
    end

`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = match_cnt + 1'b1;

    // cnt_sat is registered alongside the count so it never lags the value it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (out && !cnt_sat) begin
            match_cnt <= cnt_nxt;
            cnt_sat   <= &cnt_nxt;
        end
    end
`else
    assign match_cnt = '0;
    assign cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: five configurations share one stimulus stream and are checked
// against a sliding-window reference model through an expected-value queue.
module tb_seq_detector_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst      = 1'b1;
    logic in       = 1'b0;
    logic in_valid = 1'b0;

    logic [4:0]  outv;
    logic [4:0]  satv;
    logic [7:0]  c0, c2, c3;
    logic [1:0]  c1;
    logic [2:0]  c4;

    seq_detector_param #(.LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b0), .CNT_W(8)) d0 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .out(outv[0]), .match_cnt(c0), .cnt_sat(satv[0]));
    seq_detector_param #(.LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b1), .CNT_W(2)) d1 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .out(outv[1]), .match_cnt(c1), .cnt_sat(satv[1]));
    seq_detector_param #(.LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) d2 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .out(outv[2]), .match_cnt(c2), .cnt_sat(satv[2]));
    seq_detector_param #(.LEN(1), .PATTERN(1'b1), .OVERLAP(1'b0), .CNT_W(8)) d3 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .out(outv[3]), .match_cnt(c3), .cnt_sat(satv[3]));
    seq_detector_param #(.LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(3)) d4 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .out(outv[4]), .match_cnt(c4), .cnt_sat(satv[4]));

    logic [4:0][31:0] cobs;
    always_comb begin
        cobs    = '0;
        cobs[0] = 32'(c0);
        cobs[1] = 32'(c1);
        cobs[2] = 32'(c2);
        cobs[3] = 32'(c3);
        cobs[4] = 32'(c4);
    end

    localparam int unsigned M_LEN [5] = '{4, 4, 4, 1, 5};
    localparam logic [31:0] M_PAT [5] = '{32'b1001, 32'b1001, 32'b1010, 32'b1, 32'b11011};
    localparam bit          M_OV  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam int unsigned M_CW  [5] = '{8, 2, 8, 8, 3};

    typedef struct packed {
        logic [4:0]       out;
        logic [4:0][31:0] cnt;
        logic [4:0]       sat;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] hist = '0;
    int unsigned nb   [5] = '{0, 0, 0, 0, 0};
    int unsigned mcnt [5] = '{0, 0, 0, 0, 0};
    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string tag, input int unsigned idx,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    // One clock: drive at negedge, predict, check the Mealy pulse before the edge
    // and the registered counter after it.
    task automatic drive(input logic r, input logic b, input logic v);
        exp_t        x;
        exp_t        y;
        logic [31:0] mask;
        logic        m;
        int unsigned mx;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in       = v ? b : 1'bx;
        x        = '0;
        if (!r && v) hist = {hist[30:0], b};
        for (int unsigned i = 0; i < 5; i++) begin
            mask = (32'h1 << M_LEN[i]) - 32'h1;
            mx   = (1 << M_CW[i]) - 1;
            m    = 1'b0;
            if (r) begin
                nb[i]   = 0;
                mcnt[i] = 0;
            end else if (v) begin
                if (nb[i] < 1000) nb[i]++;
                m = (nb[i] >= M_LEN[i]) && ((hist & mask) == M_PAT[i]);
                if (m && !M_OV[i]) nb[i] = 0;
                if (m && mcnt[i] < mx) mcnt[i]++;
            end
            x.out[i] = m;
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
            x.cnt[i] = mcnt[i];
            x.sat[i] = (mcnt[i] == mx);
`else
            x.cnt[i] = 32'h0;
            x.sat[i] = 1'b0;
`endif
        end
        sbq.push_back(x);
        #1;
        y = sbq[0];
        for (int unsigned i = 0; i < 5; i++) chk("out", i, 32'(outv[i]), 32'(y.out[i]));
        @(posedge clk);
        #1;
        y = sbq.pop_front();
        for (int unsigned i = 0; i < 5; i++) begin
            chk("match_cnt", i, cobs[i], y.cnt[i]);
            chk("cnt_sat", i, 32'(satv[i]), 32'(y.sat[i]));
        end
    endtask

    task automatic run_bits(input string s);
        for (int i = 0; i < s.len(); i++) drive(1'b0, s[i] == "1", 1'b1);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        do_reset();
        run_bits("1001001");
        do_reset();
        run_bits("11001");
        do_reset();
        run_bits("1011010");
        do_reset();
        // valid gaps of two cycles between the bits of 1001
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        do_reset();
        // partial match discarded by reset, with in high while rst is asserted
        run_bits("100");
        drive(1'b1, 1'b1, 1'b1);
        run_bits("1001");
        do_reset();
        run_bits("1001001001001001");
        run_bits("11011011011011011");
        do_reset();
        for (int n = 0; n < 300; n++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 8);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
